// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response handshake with a fixed,
// parameterised response latency and per-byte write masking.
module mem_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy
);

  localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;
  logic             is_write_q;

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-offset and out-of-range address bits select nothing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_address[31:IDX_W+2], mem_address[1:0]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, and the async reset sits in the sensitivity list.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx_q      <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read || mem_write) begin
            idx_q      <= mem_address[IDX_W+1:2];
            be_q       <= mem_byte_enable;
            wdata_q    <= mem_wdata;
            is_write_q <= mem_write;  // simultaneous read+write resolves to write
            cnt        <= CNT_LOAD;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset so it maps onto plain RAM;
  // an aborted write cannot land because reset drops the FSM out of RESP first.
  always_ff @(posedge clk) begin
    if (state == RESP && is_write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign mem_resp  = (state == RESP);
  assign busy      = (state != IDLE);
  assign mem_rdata = (state == RESP && !is_write_q) ? mem[idx_q] : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios with literal
// expectations plus randomized traffic compared against a transaction model.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic [3:0]  mem_byte_enable = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        busy;

  logic        rd1 = 1'b0;
  logic [31:0] rdata1;
  logic        resp1;
  logic        busy1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(LAT), .DEPTH_WORDS(256)) u_dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy)
  );

  mem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) u_dut1 (
    .clk(clk), .rst(rst),
    .mem_read(rd1), .mem_write(1'b0),
    .mem_address(32'h0), .mem_byte_enable(4'h0),
    .mem_wdata(32'h0), .mem_rdata(rdata1),
    .mem_resp(resp1), .busy(busy1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // Periods are numbered by the clock edge that starts them. A request
  // accepted at edge p keeps the responder busy for periods p..p+LAT and
  // responds in period p+LAT; a write lands at the edge that ends it.
  int          period = 0;
  int          resp_period = -1;
  bit          in_flight = 1'b0;
  bit          t_wr;
  int          t_idx;
  logic [3:0]  t_be;
  logic [31:0] t_wd;
  logic [31:0] mdl_mem [int];
  bit          exp_busy = 1'b0;
  bit          exp_resp = 1'b0;
  bit          exp_rvalid = 1'b1;
  logic [31:0] exp_rdata = '0;

  function automatic void apply_write(input int idx, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (be == 4'hF) mdl_mem[idx] = wd;
    else if (mdl_mem.exists(idx)) mdl_mem[idx] = (mdl_mem[idx] & ~mask) | (wd & mask);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_flight = 1'b0;
    end else begin
      period++;
      if (in_flight) begin
        if (period - 1 == resp_period) begin
          if (t_wr) apply_write(t_idx, t_be, t_wd);
          in_flight = 1'b0;
        end
      end else if (mem_read || mem_write) begin
        in_flight   = 1'b1;
        t_wr        = mem_write;
        t_idx       = int'(mem_address[9:2]);
        t_be        = mem_byte_enable;
        t_wd        = mem_wdata;
        resp_period = period + LAT;
      end
    end
    exp_busy   = in_flight;
    exp_resp   = in_flight && (period == resp_period);
    exp_rvalid = 1'b1;
    exp_rdata  = '0;
    if (exp_resp && !t_wr) begin
      if (mdl_mem.exists(t_idx)) exp_rdata = mdl_mem[t_idx];
      else exp_rvalid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("resp", 32'(mem_resp), 32'(exp_resp));
      if (exp_rvalid) check("rdata", mem_rdata, exp_rdata);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_byte_enable = be; mem_wdata = wd;
  endtask

  task automatic wait_resp(input bit keep, input bit scramble, output int lat,
                           output logic [31:0] rdata, output bit all_busy);
    lat = 0; rdata = '0; all_busy = 1'b1;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (!busy) all_busy = 1'b0;
      if (mem_resp) begin
        lat = k;
        rdata = mem_rdata;
      end else if (scramble) begin
        mem_address = $urandom();
        mem_byte_enable = 4'($urandom());
        mem_wdata = $urandom();
      end
    end
    check("resp_seen", 32'(lat != 0), 32'd1);
    if (!keep) begin
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd, input bit keep,
                     output int lat, output logic [31:0] rdata);
    bit ab;
    @(negedge clk);
    issue(rd, wr, addr, be, wd);
    wait_resp(keep, 1'b1, lat, rdata, ab);
    check("busy_until_resp", 32'(ab), 32'd1);
  endtask

  function automatic logic [31:0] mk_addr(input int idx);
    return ($urandom() & 32'hFFFF_FC03) | (32'(idx) << 2);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    bit          ab;
    int          resp_cnt;
    logic [5:0]  rv;
    logic [5:0]  bv;
    int          op;
    int          idx;

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_resp", 32'(mem_resp), 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Full write then read through an address with nonzero offset bits.
    txn(1'b0, 1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 1'b0, lat, rd);
    check("wr_latency", 32'(lat), 32'd3);
    txn(1'b1, 1'b0, 32'h0000_0012, 4'h0, 32'h0, 1'b0, lat, rd);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_deadbeef", rd, 32'hDEAD_BEEF);

    txn(1'b0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 1'b0, lat, rd);
    txn(1'b1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, lat, rd);
    check("rd_partial", rd, 32'hDE22_BE44);

    txn(1'b1, 1'b1, 32'h20, 4'hF, 32'hCAFE_F00D, 1'b0, lat, rd);
    txn(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, lat, rd);
    check("rd_both_as_write", rd, 32'hCAFE_F00D);

    // Byte-enable of zero still responds and leaves the word untouched.
    txn(1'b0, 1'b1, 32'h20, 4'h0, 32'h0, 1'b0, lat, rd);
    check("be0_latency", 32'(lat), 32'd3);
    txn(1'b1, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0, lat, rd);
    check("rd_after_be0", rd, 32'hCAFE_F00D);

    // Abort a write in WAIT; reset acts without a clock edge.
    @(negedge clk);
    issue(1'b0, 1'b1, 32'h10, 4'hF, 32'h0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_resp", 32'(mem_resp), 32'd0);
    check("abort_rdata", mem_rdata, 32'd0);
    mem_write = 1'b0;
    resp_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (mem_resp) resp_cnt++;
    end
    check("abort_no_resp", 32'(resp_cnt), 32'd0);
    // Request already present when reset releases is taken on the first edge.
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
    #2 rst = 1'b1;
    wait_resp(1'b0, 1'b1, lat, rd, ab);
    check("post_reset_latency", 32'(lat), 32'd3);
    check("abort_kept_storage", rd, 32'hDE22_BE44);

    // Reset asserted during the response cycle clears the outputs at once.
    @(negedge clk);
    issue(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
    wait_resp(1'b0, 1'b0, lat, rd, ab);
    check("resp_cycle_rdata", rd, 32'hCAFE_F00D);
    #2 rst = 1'b0;
    #1;
    check("rst_in_resp_resp", 32'(mem_resp), 32'd0);
    check("rst_in_resp_rdata", mem_rdata, 32'd0);
    check("rst_in_resp_busy", 32'(busy), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Held read with LATENCY=1: responses on cycles 2 and 5.
    @(negedge clk);
    rd1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rv[k] = resp1;
      bv[k] = busy1;
    end
    rd1 = 1'b0;
    check("lat1_resp_pattern", 32'(rv), 32'(6'b010010));
    check("lat1_busy_pattern", 32'(bv), 32'(6'b011011));

    // Preload a working set, then randomized traffic.
    for (int i = 0; i < 17; i++) begin
      idx = (i == 16) ? 255 : i;
      txn(1'b0, 1'b1, mk_addr(idx), 4'hF, $urandom(), 1'b0, lat, rd);
    end
    for (int n = 0; n < 150; n++) begin
      op  = int'($urandom_range(0, 3));
      idx = ($urandom_range(0, 16) == 16) ? 255 : int'($urandom_range(0, 15));
      txn(op != 2, op >= 2, mk_addr(idx), 4'($urandom()), $urandom(),
          bit'($urandom_range(0, 1)), lat, rd);
      check("rand_latency", 32'(lat), 32'(LAT + 1));
    end
    mem_read = 1'b0;
    mem_write = 1'b0;
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, giving wait cycles from request acceptance to mem_resp; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit storage words (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_read  input  1  read request; held by initiator until mem_resp.
REQ-006 SHALL have port mem_write  input  1  write request; held by initiator until mem_resp.
REQ-007 SHALL have port mem_address  input  32  byte address; bits [1:0] ignored; word index = bits [log2(DEPTH_WORDS)+1:2]; upper bits ignored.
REQ-008 SHALL have port mem_byte_enable  input  4  per-byte write mask; bit i enables byte lane [8i+7:8i].
REQ-009 SHALL have port mem_wdata  input  32  write data.
REQ-010 SHALL have port mem_rdata  output  32  read data; valid only in the mem_resp cycle.
REQ-011 SHALL have port mem_resp  output  1  single-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high from acceptance through the mem_resp cycle.

Function
REQ-013 SHALL implement three states: IDLE, WAIT, RESP.
REQ-014 In IDLE with mem_read or mem_write high at a clock edge, SHALL capture address, byte_enable, wdata and op, load counter with LATENCY-1, and move to WAIT.
REQ-015 If mem_read and mem_write are both high at acceptance, SHALL treat the request as a write.
REQ-016 In WAIT, SHALL decrement the counter each cycle and move to RESP on the edge where the counter equals 0.
REQ-017 mem_resp SHALL be high exactly while in RESP, which lasts one cycle, giving mem_resp LATENCY+1 cycles after the acceptance edge.
REQ-018 On a read, mem_rdata in the RESP cycle SHALL equal the stored word at the captured index; outside RESP mem_rdata SHALL be 0.
REQ-019 On a write, SHALL update only the enabled byte lanes of the captured word on the edge leaving RESP; byte_enable 4'b0000 SHALL leave storage unchanged and still pulse mem_resp.
REQ-020 Inputs changing after acceptance SHALL NOT affect the in-flight request.
REQ-021 From RESP, SHALL return to IDLE unconditionally; a request still high in the cycle after RESP SHALL be accepted as a new request.
REQ-022 A read of a word in the same transaction order after a write SHALL return the written data (write-then-read coherent).
REQ-023 Requests while in WAIT or RESP SHALL be ignored apart from the in-flight one.
REQ-024 busy SHALL equal (state != IDLE).

Reset
REQ-025 Asserting rst low SHALL immediately, without clock, force state to IDLE, mem_resp to 0, busy to 0, mem_rdata to 0, and the counter to 0.
REQ-026 Reset mid-transaction SHALL abort it: no mem_resp, and a pending write SHALL NOT modify storage.
REQ-027 Storage contents SHALL be unaffected by reset; contents before first write are undefined.
REQ-028 After rst deasserts, the first request SHALL be acceptable on the first rising clk edge.

Verification
REQ-029 Write 0xDEADBEEF to 0x0000_0010 with byte_enable 4'b1111, LATENCY=2 -> mem_resp high exactly on cycle 3 after acceptance, one cycle wide; busy high cycles 1-3.
REQ-030 Then read 0x0000_0012 -> mem_rdata = 0xDEADBEEF in the mem_resp cycle, 0 in all other cycles.
REQ-031 Write 0x11223344 to 0x10 with byte_enable 4'b0101, then read 0x10 -> 0xDE22BE44.
REQ-032 Assert mem_read and mem_write together with wdata 0xCAFEF00D at 0x20, then read 0x20 -> 0xCAFEF00D.
REQ-033 Write 0x0 to 0x10, pull rst low during WAIT, release, read 0x10 -> 0xDE22BE44 and no mem_resp during the aborted transaction.
REQ-034 Hold mem_read high continuously for two reads with LATENCY=1 -> mem_resp pulses on cycles 2 and 5, separated by one IDLE acceptance cycle.
